// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared access-type codes, MMIO offsets and STATUS bit positions
package dmem_pkg;

    localparam logic [2:0] DM_WORD  = 3'd0;
    localparam logic [2:0] DM_HALF  = 3'd1;
    localparam logic [2:0] DM_HALFU = 3'd2;
    localparam logic [2:0] DM_BYTE  = 3'd3;
    localparam logic [2:0] DM_BYTEU = 3'd4;

    localparam logic [3:0] MMIO_TX     = 4'h0;
    localparam logic [3:0] MMIO_STATUS = 4'h4;
    localparam logic [3:0] MMIO_CYC_LO = 4'h8;
    localparam logic [3:0] MMIO_CYC_HI = 4'hC;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } acc_size_e;

    // Reserved codes fall through to word.
    function automatic acc_size_e size_of(input logic [2:0] t);
        case (t)
            DM_HALF, DM_HALFU: size_of = SZ_HALF;
            DM_BYTE, DM_BYTEU: size_of = SZ_BYTE;
            default:           size_of = SZ_WORD;
        endcase
    endfunction

    function automatic logic is_signed(input logic [2:0] t);
        is_signed = (t == DM_HALF) || (t == DM_BYTE);
    endfunction

endpackage

// File: rtl/dmem_txq.sv
// rtl/dmem_txq.sv - parameterised circular byte FIFO for the console TX queue
module dmem_txq
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    fifo_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    // A push into a full queue only lands when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = empty ? 8'h00 : fifo_q[rd_q];

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
        if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
        if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) fifo_q[wr_q] <= din;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: byte-lane RAM, fault capture, optional MMIO (DMEM_MMIO_EN)
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          TXQ_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dm_type,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [AW-1:0] idx;
    acc_size_e     sz;
    logic          misal, ram_hit, in_mmio, bad, fault_ev, ram_we;
    logic [3:0]    be;
    logic [31:0]   wlanes, rword, ram_ld, mmio_rd;
    logic [15:0]   hsel;
    logic [7:0]    bsel;
    logic          fault_q, fault_d;
    logic [31:0]   fault_addr_q, fault_addr_d;

    assign idx     = addr[AW+1:2];
    assign sz      = size_of(dm_type);
    assign misal   = ((sz == SZ_HALF) && addr[0]) || ((sz == SZ_WORD) && (addr[1:0] != 2'b00));
    assign ram_hit = ({1'b0, addr} < RAM_BYTES);
    // MMIO registers accept word accesses only.
    assign bad      = misal || !(ram_hit || in_mmio) || (in_mmio && (sz != SZ_WORD));
    assign fault_ev = (mem_w || mem_r) && bad;
    assign ram_we   = mem_w && ram_hit && !bad;

    always_comb begin
        be     = 4'hF;
        wlanes = wdata;
        case (sz)
            SZ_HALF: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    // Stores are written even while reset is asserted; RAM has no reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    assign rword = mem_q[idx];
    assign hsel  = addr[1] ? rword[31:16] : rword[15:0];
    assign bsel  = rword[{addr[1:0], 3'b000} +: 8];

    always_comb begin
        ram_ld = rword;
        case (sz)
            SZ_HALF: ram_ld = is_signed(dm_type) ? {{16{hsel[15]}}, hsel} : {16'h0, hsel};
            SZ_BYTE: ram_ld = is_signed(dm_type) ? {{24{bsel[7]}}, bsel} : {24'h0, bsel};
            default: ;
        endcase
    end

    assign rdata = bad ? 32'h0 : (in_mmio ? mmio_rd : ram_ld);

    assign fault_d      = fault_q || fault_ev;
    assign fault_addr_d = (fault_ev && !fault_q) ? addr : fault_addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_off;
    logic [63:0] cyc_q, cyc_d;
    logic [31:0] shadow_q, shadow_d;
    logic        ovf_q, ovf_d;
    logic        tx_push, tx_pop, q_full, q_empty;
    logic [7:0]  q_head;

    assign mmio_off = addr - MMIO_BASE;
    assign in_mmio  = (mmio_off < 32'd16);
    assign tx_push  = mem_w && in_mmio && !bad && (mmio_off[3:0] == MMIO_TX);
    assign tx_pop   = !q_empty && tx_ready;
    assign ovf_d    = ovf_q || (tx_push && q_full && !tx_pop);
    assign cyc_d    = cyc_q + 64'd1;
    // Reading CYC_LO freezes the high half so a following CYC_HI read is coherent.
    assign shadow_d = (mem_r && in_mmio && !bad && (mmio_off[3:0] == MMIO_CYC_LO)) ? cyc_q[63:32] : shadow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q    <= 64'h0;
            shadow_q <= 32'h0;
            ovf_q    <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        mmio_rd = 32'h0;
        case (mmio_off[3:0])
            MMIO_STATUS: begin
                mmio_rd[ST_EMPTY] = q_empty;
                mmio_rd[ST_FULL]  = q_full;
                mmio_rd[ST_OVF]   = ovf_q;
            end
            MMIO_CYC_LO: mmio_rd = cyc_q[31:0];
            MMIO_CYC_HI: mmio_rd = shadow_q;
            default:     ;
        endcase
    end

    dmem_txq #(.DEPTH(TXQ_DEPTH)) u_txq (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign tx_valid = !q_empty;
    assign tx_data  = q_head;
`else
    logic unused_mmio;

    assign in_mmio     = 1'b0;
    assign mmio_rd     = 32'h0;
    assign tx_valid    = 1'b0;
    assign tx_data     = 8'h00;
    assign unused_mmio = tx_ready ^ (MMIO_BASE[0] ^ (TXQ_DEPTH == 0));
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl (RAM vectors, fault capture, MMIO when DMEM_MMIO_EN)
module tb_dmem_ctrl;

    localparam logic [31:0] B = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_w, mem_r;
    logic [31:0] addr, wdata;
    logic [2:0]  dm_type;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        fault;
    logic [31:0] fault_addr;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        w;
        logic        r;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH_WORDS(1024), .MMIO_BASE(B), .TXQ_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_w      (mem_w),
        .mem_r      (mem_r),
        .addr       (addr),
        .wdata      (wdata),
        .dm_type    (dm_type),
        .rdata      (rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request cycle: drive at the falling edge, sample rdata 1 ns later.
    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] t, input logic chk, input logic [31:0] exp);
        logic [31:0] e;
        @(negedge clk);
        reset   = 1'b0;
        mem_w   = w;
        mem_r   = r;
        addr    = a;
        wdata   = d;
        dm_type = t;
        if (chk) exp_q.push_back(exp);
        #1;
        if (chk) begin
            e = exp_q.pop_front();
            check($sformatf("rdata@%h/t%0d", a, t), rdata, e);
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_w = 1'b0;
        mem_r = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; mem_w = 1'b0; mem_r = 1'b0; addr = 32'h0; wdata = 32'h0;
        dm_type = 3'd0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset fault", {31'h0, fault}, 32'h0);
        check("reset fault_addr", fault_addr, 32'h0);
        check("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        check("reset tx_data", {24'h0, tx_data}, 32'h0);

        vecs.push_back('{1'b1, 1'b0, 32'h10,  32'h8899AABC, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h11,  32'h0,        3'd3, 1'b1, 32'hFFFFFFAA});
        vecs.push_back('{1'b0, 1'b1, 32'h11,  32'h0,        3'd4, 1'b1, 32'h000000AA});
        vecs.push_back('{1'b0, 1'b1, 32'h10,  32'h0,        3'd0, 1'b1, 32'h8899AABC});
        vecs.push_back('{1'b0, 1'b1, 32'h12,  32'h0,        3'd1, 1'b1, 32'hFFFF8899});
        vecs.push_back('{1'b0, 1'b1, 32'h12,  32'h0,        3'd2, 1'b1, 32'h00008899});
        vecs.push_back('{1'b1, 1'b0, 32'h20,  32'hFFFFFFFF, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h22,  32'hDEAD1234, 3'd1, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h20,  32'h0,        3'd0, 1'b1, 32'h1234FFFF});
        vecs.push_back('{1'b1, 1'b0, 32'h30,  32'h0,        3'd0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h33,  32'hFFFFFF5A, 3'd3, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'h30,  32'h0,        3'd0, 1'b1, 32'h5A000000});
        vecs.push_back('{1'b0, 1'b1, 32'h32,  32'h0,        3'd1, 1'b1, 32'h00005A00});
        vecs.push_back('{1'b1, 1'b0, 32'h40,  32'h11111111, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{1'b1, 1'b1, 32'h40,  32'h22222222, 3'd0, 1'b1, 32'h11111111});
        vecs.push_back('{1'b0, 1'b1, 32'h40,  32'h0,        3'd0, 1'b1, 32'h22222222});
        vecs.push_back('{1'b1, 1'b0, 32'hFFC, 32'hCAFEBABE, 3'd0, 1'b0, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'hFFC, 32'h0,        3'd0, 1'b1, 32'hCAFEBABE});
        vecs.push_back('{1'b0, 1'b1, 32'h40,  32'h0,        3'd7, 1'b1, 32'h22222222});

        foreach (vecs[i]) step(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].t, vecs[i].chk, vecs[i].exp);
        idle();
        check("no fault after vectors", {31'h0, fault}, 32'h0);

        // Misaligned half load, then misaligned store suppressed, then good accesses.
        step(1'b1, 1'b0, 32'h24, 32'hA5A5A5A5, 3'd0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h23, 32'h0, 3'd1, 1'b1, 32'h0);
        check("fault not yet", {31'h0, fault}, 32'h0);
        step(1'b1, 1'b0, 32'h25, 32'h0000BEEF, 3'd1, 1'b1, 32'h0);
        check("fault set", {31'h0, fault}, 32'h1);
        check("fault_addr first", fault_addr, 32'h23);
        step(1'b0, 1'b1, 32'h24, 32'h0, 3'd0, 1'b1, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 32'h30, 32'h12345678, 3'd0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h30, 32'h0, 3'd0, 1'b1, 32'h12345678);
        step(1'b0, 1'b1, 32'h1000, 32'h0, 3'd0, 1'b1, 32'h0);
        idle();
        check("fault_addr sticky", fault_addr, 32'h23);
        check("fault sticky", {31'h0, fault}, 32'h1);

        do_reset();
        check("fault cleared", {31'h0, fault}, 32'h0);

`ifdef DMEM_MMIO_EN
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, B, 32'h41 + i, 3'd0, 1'b0, 32'h0);
            if (i == 1) begin
                check("tx_valid after push", {31'h0, tx_valid}, 32'h1);
                check("tx_data head", {24'h0, tx_data}, 32'h41);
            end
        end
        step(1'b0, 1'b1, B + 32'h4, 32'h0, 3'd0, 1'b1, 32'h6);
        step(1'b0, 1'b1, B, 32'h0, 3'd0, 1'b1, 32'h0);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain valid %0d", i), {31'h0, tx_valid}, 32'h1);
            check($sformatf("drain data %0d", i), {24'h0, tx_data}, 32'h41 + i);
            idle();
        end
        check("drained valid", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        step(1'b0, 1'b1, B + 32'h4, 32'h0, 3'd0, 1'b1, 32'h5);

        // Coherent 64-bit read across the 32-bit carry.
        @(negedge clk);
        mem_r = 1'b0;
        force dut.cyc_d = 64'h0000_0000_FFFF_FFFF;
        @(negedge clk);
        release dut.cyc_d;
        mem_r = 1'b1; addr = B + 32'h8; dm_type = 3'd0;
        #1;
        check("cyc_lo pre-carry", rdata, 32'hFFFFFFFF);
        step(1'b0, 1'b1, B + 32'hC, 32'h0, 3'd0, 1'b1, 32'h0);
        step(1'b0, 1'b1, B + 32'h8, 32'h0, 3'd0, 1'b1, 32'h1);
        step(1'b0, 1'b1, B + 32'hC, 32'h0, 3'd0, 1'b1, 32'h1);

        step(1'b0, 1'b1, B + 32'h4, 32'h0, 3'd3, 1'b1, 32'h0);
        idle();
        check("mmio byte fault", {31'h0, fault}, 32'h1);
        check("mmio byte fault_addr", fault_addr, B + 32'h4);

        step(1'b1, 1'b0, B, 32'h99, 3'd0, 1'b0, 32'h0);
        idle();
        check("queue nonempty pre-reset", {31'h0, tx_valid}, 32'h1);
`else
        step(1'b0, 1'b1, B + 32'h4, 32'h0, 3'd0, 1'b1, 32'h0);
        step(1'b1, 1'b0, B, 32'h41, 3'd0, 1'b0, 32'h0);
        check("mmio range fault", {31'h0, fault}, 32'h1);
        check("mmio range fault_addr", fault_addr, B + 32'h4);
        idle();
        check("tx_valid tied low", {31'h0, tx_valid}, 32'h0);
`endif

        // One-cycle reset with a store in flight: store lands, state clears.
        @(negedge clk);
        reset = 1'b1; mem_w = 1'b1; mem_r = 1'b0; addr = 32'h50; wdata = 32'h0000600D; dm_type = 3'd0;
        @(negedge clk);
        reset = 1'b0; mem_w = 1'b0;
`ifdef DMEM_MMIO_EN
        mem_r = 1'b1; addr = B + 32'h8;
        #1;
        check("counter restart", rdata, 32'h0);
        step(1'b0, 1'b1, B + 32'h8, 32'h0, 3'd0, 1'b1, 32'h1);
`else
        #1;
`endif
        check("post-reset fault", {31'h0, fault}, 32'h0);
        check("post-reset fault_addr", fault_addr, 32'h0);
        check("post-reset tx_valid", {31'h0, tx_valid}, 32'h0);
        step(1'b0, 1'b1, 32'h50, 32'h0, 3'd0, 1'b1, 32'h0000600D);

        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
